fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage; successor to the single-cycle, reset-cleared fetch array.
//  - Owns the PC and issues word-aligned requests to an external instruction memory over a req/rsp handshake.
//  - Buffers returned words with their PC in a prefetch FIFO and hands them to decode over valid/ready.
//  - Accepts branch/jump redirects that flush all stale work.
// PARAMETERS
//  XLEN             32       PC / address width
//  ILEN             32       instruction width
//  FIFO_DEPTH       4        prefetch FIFO entries (power of 2, >=2)
//  MAX_OUTSTANDING  2        max memory requests in flight (>=1)
//  RESET_PC         32'h0    PC value after reset
// PORTS
//  clk              in   1     clock, rising edge
//  n_rst            in   1     asynchronous reset, active low
//  redirect_valid   in   1     load new PC this cycle (branch/jump)
//  redirect_pc      in   XLEN  redirect target
//  imem_req_valid   out  1     fetch request valid
//  imem_req_ready   in   1     memory accepts request
//  imem_req_addr    out  XLEN  byte address of request (word aligned)
//  imem_rsp_valid   in   1     response valid (in order, no backpressure)
//  imem_rsp_data    in   ILEN  response instruction word
//  instr_valid      out  1     instr/instr_pc valid to decode
//  instr_ready      in   1     decode accepts
//  instr            out  ILEN  instruction word
//  instr_pc         out  XLEN  PC of instr
//  instr_fault      out  1     misaligned-target fault (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: pc=RESET_PC; FIFO empty; outstanding=0; drop=0; all outputs 0.
//  - Request: imem_req_valid=1 iff !redirect_valid && outstanding+fifo_count < FIFO_DEPTH
//    && outstanding < MAX_OUTSTANDING.
//    - imem_req_addr = pc; on req_valid&&req_ready: pc+=4, outstanding++.
//    - Credit rule guarantees every response has a FIFO slot: never overflow, never drop a valid response.
//  - Response: on rsp_valid, outstanding--.
//    - If drop>0: drop--, word discarded.
//    - Else push {pc_tag, data}; pc_tag is a separate counter advanced +4 per accepted response.
//    - Response latency >=1 cycle after request accept; rsp same cycle as new req accept: both counted.
//  - Output: instr/instr_pc/instr_valid come from FIFO head (registered storage, comb read);
//    pop on instr_valid&&instr_ready.
//    - Empty FIFO: instr_valid=0.
//    - Push and pop in same cycle with count unchanged is legal at full and at empty+1.
//  - Redirect (highest priority): next cycle pc=pc_tag=redirect_pc, FIFO flushed,
//    drop = outstanding minus any response arriving this cycle; no request issued that cycle.
//    - A handshake on instr in the redirect cycle counts as consumed.
//    - Back-to-back redirects: the last one wins; drop keeps counting all in-flight.
//  - Arithmetic: pc wraps modulo 2**XLEN; counters sized $clog2(FIFO_DEPTH)+1.
//  - Reset mid-operation: state clears immediately; late responses after reset are outside protocol.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN:
//  - Defined: a redirect with redirect_pc[1:0]!=0 sets a fault state.
//    - FIFO flushed, no further requests issued.
//    - instr_valid=1, instr_fault=1, instr=0, instr_pc=redirect_pc; held until accepted.
//    - After acceptance, fetch stays halted until the next aligned redirect.
//  - Undefined: redirect_pc[1:0] ignored (forced to 00); instr_fault tied 0.
// STRUCTURE
//  - fetch_pkg: XLEN/ILEN defaults, INSTR_BYTES=4, typedef fetch_entry_t {logic [XLEN-1:0] pc;
//    logic [ILEN-1:0] instr;}.
//  - Sub-module fetch_fifo: sync FIFO of fetch_entry_t with push/pop/flush, count, full, empty.
//  - Top holds pc, pc_tag, outstanding, drop, fault state.
// TESTING
//  1. Reset, 1-cycle memory, instr_ready=1 -> instr_pc 0,4,8,... one per cycle after fill;
//     imem_req_addr never repeats.
//  2. instr_ready=0 for 20 cycles -> exactly FIFO_DEPTH requests issued, req_valid then 0;
//     release -> in-order drain, no loss.
//  3. 3-cycle memory latency -> outstanding never exceeds MAX_OUTSTANDING; throughput = MAX_OUTSTANDING/3.
//  4. Redirect to 0x100 with 2 requests in flight -> both responses dropped; first instr_pc=0x100.
//  5. Redirect in same cycle as rsp_valid and instr handshake -> that response dropped,
//     popped entry counted consumed, FIFO empty next cycle.
//  6. (FETCH_MISALIGN_CHECK_EN) redirect to 0x102 -> instr_fault=1, instr_pc=0x102, no imem requests;
//     redirect to 0x200 -> fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, entry type and fetch FSM states.
// No ports; imported by fetch_fifo and fetch_unit.
package fetch_pkg;

   localparam int DEF_XLEN    = 32;
   localparam int DEF_ILEN    = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_ILEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_RUN,
      FS_FAULT,
      FS_HALT
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync prefetch FIFO, registered storage, comb head read.
// Ports: clk, n_rst, push/wdata, pop/rdata, flush, count, full, empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = $bits(fetch_entry_t)
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   // a pop frees the slot, so push at full is fine then
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/rsp with credit, prefetch FIFO to decode.
// Ports: clk, n_rst, redirect_*, imem_req_*, imem_rsp_*, instr_*.
// Option: FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect fault.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               XLEN            = DEF_XLEN,
   parameter int               ILEN            = DEF_ILEN,
   parameter int               FIFO_DEPTH      = 4,
   parameter int               MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0]  RESET_PC        = '0
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = XLEN + ILEN;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tag_q, tag_d;
   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   fifo_cnt;
   logic [XLEN-1:0] target;
   logic [EW-1:0]   rdata;
   logic            misalign, room, req_fire;
   logic            push, pop, fifo_full, fifo_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign target      = redirect_pc;
   assign misalign    = redirect_pc[1:0] != 2'b00;
   assign instr_fault = state_q == FS_FAULT;
`else
   assign target      = redirect_pc & ~XLEN'(3);
   assign misalign    = 1'b0;
   assign instr_fault = 1'b0;
`endif

   // outstanding reserves a FIFO slot, so responses never overflow
   assign room = !fifo_full
              && (32'(outst_q) + 32'(fifo_cnt)) < 32'(FIFO_DEPTH)
              && 32'(outst_q) < 32'(MAX_OUTSTANDING);

   assign imem_req_valid = state_q == FS_RUN && !redirect_valid && room;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign push = imem_rsp_valid && drop_q == '0 && !redirect_valid;
   assign pop  = instr_valid && instr_ready && state_q != FS_FAULT;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (push),
      .wdata ({tag_q, imem_rsp_data}),
      .pop   (pop),
      .flush (redirect_valid),
      .rdata (rdata),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      instr_valid = 1'b0;
      instr       = '0;
      instr_pc    = '0;
      if (state_q == FS_FAULT) begin
         instr_valid = 1'b1;
         instr_pc    = fpc_q;
      end else if (!fifo_empty) begin
         instr_valid       = 1'b1;
         {instr_pc, instr} = rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tag_d   = tag_q;
      fpc_d   = fpc_q;
      drop_d  = drop_q;
      outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (req_fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid) begin
         if (drop_q != '0) drop_d = drop_q - 1'b1;
         else              tag_d  = tag_q + XLEN'(INSTR_BYTES);
      end
      unique case (state_q)
         FS_IDLE:  state_d = FS_RUN;
         FS_FAULT: if (instr_ready) state_d = FS_HALT;
         default:  state_d = state_q;
      endcase
      // every request still in flight after this edge is stale
      if (redirect_valid) begin
         pc_d    = target;
         tag_d   = target;
         fpc_d   = redirect_pc;
         drop_d  = outst_q - CW'(imem_rsp_valid);
         state_d = misalign ? FS_FAULT : FS_RUN;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= FS_IDLE;
         pc_q    <= RESET_PC;
         tag_q   <= RESET_PC;
         fpc_q   <= '0;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tag_q   <= tag_d;
         fpc_q   <= fpc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-modelled imem.
// Honours FETCH_MISALIGN_CHECK_EN when defined.
module tb_fetch_unit;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        n_rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;
   logic        instr_fault;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

   pend_t       pend_q[$];
   exp_t        sb_q[$];
   int          tests = 0, fails = 0;
   int          cyc = 0, lat = 1, last_due = 0;
   int          req_cnt = 0, hs_cnt = 0;
   logic [31:0] exp_req_addr, fault_pc, first_pc;
   bit          halted, fault_pend, chk_empty;

   fetch_unit dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_fault    (instr_fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act,
                          input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // memory: in-order responses, one per cycle, after the modelled latency
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         if (n_rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(pend_q[0].addr);
            void'(pend_q.pop_front());
         end
      end
   end

   // request observer: address model and expected-stream producer
   initial begin
      int infl, due;
      forever begin
         @(negedge clk);
         #3;
         if (!n_rst) continue;
         infl = pend_q.size() + (imem_rsp_valid ? 1 : 0);
         chk_rng("outstanding", infl, 0, MAXO);
         if (halted || redirect_valid)
            chk("req_quiet", {31'd0, imem_req_valid}, 32'd0);
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req_addr);
            sb_q.push_back('{pc: exp_req_addr, data: memfn(exp_req_addr)});
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            pend_q.push_back('{addr: imem_req_addr, due: due});
            exp_req_addr += 32'd4;
            req_cnt++;
         end
         if (redirect_valid) begin
            exp_req_addr = FAULT_EN ? redirect_pc : (redirect_pc & ~32'd3);
            halted = FAULT_EN && redirect_pc[1:0] != 2'b00;
         end
      end
   end

   // output monitor: pops the scoreboard on every decode handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (!n_rst) continue;
         if (chk_empty && !fault_pend)
            chk("empty_after_redirect", {31'd0, instr_valid}, 32'd0);
         chk_empty = 1'b0;
         if (fault_pend) begin
            chk("fault_valid", {31'd0, instr_valid}, 32'd1);
            chk("fault_flag", {31'd0, instr_fault}, 32'd1);
            chk("fault_instr", instr, 32'd0);
            chk("fault_pc", instr_pc, fault_pc);
            if (instr_ready) fault_pend = 1'b0;
         end else if (instr_valid && instr_ready) begin
            if (hs_cnt == 0) first_pc = instr_pc;
            hs_cnt++;
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_instr: got pc %h want none", instr_pc);
            end else begin
               e = sb_q.pop_front();
               chk("instr_pc", instr_pc, e.pc);
               chk("instr", instr, e.data);
               chk("no_fault", {31'd0, instr_fault}, 32'd0);
            end
         end
         if (redirect_valid) begin
            sb_q.delete();
            if (FAULT_EN && redirect_pc[1:0] != 2'b00) begin
               fault_pend = 1'b1;
               fault_pc   = redirect_pc;
            end else begin
               fault_pend = 1'b0;
               chk_empty  = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic redirect(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc    = t;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_first(input string nm, input logic [31:0] want);
      hs_cnt = 0;
      for (int k = 0; k < 40 && hs_cnt == 0; k++) step();
      chk_rng({nm, "_seen"}, hs_cnt, 1, 1000);
      chk(nm, first_pc, want);
   endtask

   initial begin
      logic [31:0] r, t;
      n_rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b0;
      instr_ready = 1'b0;
      exp_req_addr = '0;
      halted = 1'b0;
      fault_pend = 1'b0;
      chk_empty = 1'b0;
      #1 n_rst = 1'b0;
      #2;
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'd0);
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_fault", {31'd0, instr_fault}, 32'd0);
      repeat (2) step();
      n_rst = 1'b1;
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;

      wait_first("t1_first_pc", 32'h0);
      repeat (8) step();
      hs_cnt = 0;
      repeat (20) step();
      chk("t1_one_per_cycle", hs_cnt, 32'd20);

      instr_ready = 1'b0;
      redirect(32'h40);
      req_cnt = 0;
      repeat (20) step();
      chk("t2_req_count", req_cnt, DEPTH);
      chk("t2_req_idle", {31'd0, imem_req_valid}, 32'd0);
      instr_ready = 1'b1;
      hs_cnt = 0;
      repeat (10) step();
      chk_rng("t2_drain", hs_cnt, DEPTH, 10);

      lat = 2;
      repeat (12) step();
      hs_cnt = 0;
      repeat (30) step();
      chk_rng("t3_throughput", hs_cnt, 19, 21);

      lat = 3;
      repeat (10) step();
      redirect(32'h100);
      wait_first("t4_first_pc", 32'h100);

      lat = 1;
      repeat (8) step();
      redirect(32'h300);
      chk("t5_empty", {31'd0, instr_valid}, 32'd0);

      instr_ready = 1'b0;
      redirect(32'h102);
      req_cnt = 0;
      repeat (20) step();
      chk("t6_req_count", req_cnt, FAULT_EN ? 32'd0 : DEPTH);
      instr_ready = 1'b1;
      repeat (8) step();
      redirect(32'h200);
      wait_first("t6_resume_pc", 32'h200);

      for (int i = 0; i < 800; i++) begin
         r = $urandom;
         imem_req_ready = (r[1:0] != 2'b00);
         instr_ready = (r[3:2] != 2'b00);
         lat = 1 + int'(r[5:4]);
         redirect_valid = (r[10:6] == 5'd0) || (r[10:6] == 5'd1);
         t = {16'd0, r[31:18], 2'b00};
         if (r[12:11] == 2'b00) t[1:0] = r[14:13];
         if (r[17:15] == 3'd0) t = 32'hFFFF_FFF0;
         redirect_pc = t;
         step();
      end
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;
      lat = 1;
      redirect(32'h80);
      wait_first("final_first_pc", 32'h80);
      repeat (6) step();
      hs_cnt = 0;
      repeat (10) step();
      chk("final_flow", hs_cnt, 32'd10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
